// File: rtl/perceptron_pkg.sv
`default_nettype none
// ============================================================================
// Package  : perceptron_pkg
// Brief    : Shared word width, sequencer state encoding and signed threshold
//            compare for the perceptron sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package perceptron_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    RESULT = 2'd2,
    UPDATE = 2'd3
  } state_t;

  function automatic logic sum_ge_thresh(input logic [WORD_W-1:0] sum,
                                         input logic [WORD_W-1:0] thresh);
    return $signed(sum) >= $signed(thresh);
  endfunction

endpackage
`default_nettype wire

// File: rtl/perceptron_weight_bank.sv
`default_nettype none
// ============================================================================
// Module   : perceptron_weight_bank
// Brief    : N x 32-bit weight registers with a single cfg write port, a flat
//            read bus and a masked +/-ETA update port.
// Revision : 1.0 - initial release
// ============================================================================
module perceptron_weight_bank
  import perceptron_pkg::*;
#(
  parameter int N   = 8,
  parameter int ETA = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_en,
  input  logic [$clog2(N)-1:0]  cfg_idx,
  input  logic [WORD_W-1:0]     cfg_wdata,
  input  logic                  upd_en,
  input  logic [N-1:0]          upd_mask,
  input  logic                  upd_inc,
  output logic [WORD_W*N-1:0]   rd_bus
);

  localparam int                C_IDX_W = $clog2(N);
  localparam logic [WORD_W-1:0] C_ETA   = WORD_W'(ETA);

  logic [WORD_W-1:0] w_step;

  // Two's complement negation so the update simply wraps modulo 2^32.
  assign w_step = upd_inc ? C_ETA : (~C_ETA) + WORD_W'(1);

  for (genvar i = 0; i < N; i++) begin : g_word
    logic [WORD_W-1:0] r_w;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_w <= '0;
      end else if (cfg_en && (cfg_idx == C_IDX_W'(i))) begin
        r_w <= cfg_wdata;
      end else if (upd_en && upd_mask[i]) begin
        r_w <= r_w + w_step;
      end
    end

    assign rd_bus[WORD_W*i +: WORD_W] = r_w;
  end

endmodule
`default_nettype wire

// File: rtl/perceptron_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : perceptron_sequencer
// Brief    : Issues one input vector at a time to an external weighted_sum
//            datapath, thresholds the returned sum and hands out the class.
//            Optional on-line training: PERCEPTRON_TRAIN_EN.
// Revision : 1.0 - initial release
// ============================================================================
module perceptron_sequencer
  import perceptron_pkg::*;
#(
  parameter int N   = 8,
  parameter int LAT = N,
  parameter int ETA = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_we,
  input  logic [$clog2(N)-1:0]  cfg_idx,
  input  logic [WORD_W-1:0]     cfg_wdata,
  output logic                  cfg_ready,
  input  logic [WORD_W-1:0]     thresh,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N-1:0]          in_x,
  input  logic                  in_label,
  output logic [N-1:0]          ws_x,
  output logic [WORD_W*N-1:0]   ws_w,
  input  logic [WORD_W-1:0]     ws_sum,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_class,
  output logic [WORD_W-1:0]     out_sum
);

  localparam int                 C_CNT_W   = $clog2(LAT + 1);
  localparam logic [C_CNT_W-1:0] C_CAPTURE = C_CNT_W'(LAT);

  state_t              r_state;
  logic [C_CNT_W-1:0]  r_cnt;
  logic [WORD_W-1:0]   r_thresh;
  logic                w_accept;
  logic                w_cfg_en;
  logic                w_mismatch;
  logic                w_upd_en;
  logic                w_upd_inc;

  assign cfg_ready = (r_state == IDLE);
  assign in_ready  = cfg_ready & ~cfg_we;
  assign w_accept  = in_valid & in_ready;
  assign w_cfg_en  = cfg_ready & cfg_we & (32'(cfg_idx) < N);

`ifdef PERCEPTRON_TRAIN_EN
  logic r_label;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_label <= 1'b0;
    end else if (w_accept) begin
      r_label <= in_label;
    end
  end

  assign w_mismatch = (out_class != r_label);
  assign w_upd_en   = (r_state == UPDATE);
  assign w_upd_inc  = r_label;
`else
  logic w_unused_label;
  assign w_unused_label = in_label;
  assign w_mismatch     = 1'b0;
  assign w_upd_en       = 1'b0;
  assign w_upd_inc      = 1'b0;
`endif

  // ws_x lands one edge after accept, so the sum is valid LAT edges after that
  // and is captured on the following edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_thresh  <= '0;
      ws_x      <= '0;
      out_valid <= 1'b0;
      out_class <= 1'b0;
      out_sum   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            ws_x     <= in_x;
            r_thresh <= thresh;
            r_cnt    <= '0;
            r_state  <= ISSUE;
          end
        end
        ISSUE: begin
          if (r_cnt == C_CAPTURE) begin
            out_sum   <= ws_sum;
            out_class <= sum_ge_thresh(ws_sum, r_thresh);
            out_valid <= 1'b1;
            r_state   <= RESULT;
          end else begin
            r_cnt <= r_cnt + C_CNT_W'(1);
          end
        end
        RESULT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            r_state   <= w_mismatch ? UPDATE : IDLE;
          end
        end
        UPDATE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  perceptron_weight_bank #(
    .N   (N),
    .ETA (ETA)
  ) u_weight_bank (
    .clk       (clk),
    .rst       (rst),
    .cfg_en    (w_cfg_en),
    .cfg_idx   (cfg_idx),
    .cfg_wdata (cfg_wdata),
    .upd_en    (w_upd_en),
    .upd_mask  (ws_x),
    .upd_inc   (w_upd_inc),
    .rd_bus    (ws_w)
  );

endmodule
`default_nettype wire
